// File: rtl/uart_trans_cfg.sv
// Parametrised UART transceiver with FWFT TX/RX FIFOs,
// configurable framing and sticky receive error flags.

module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot for a write into a full FIFO
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

module uart_trans_cfg #(
    parameter int BAUDRATE  = 2304000,
    parameter int CLOCKRATE = 80000000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       send_flag,
    input  logic [7:0] send_data,
    input  logic       recv_flag,
    output logic [7:0] recv_data,
    output logic       sendable,
    output logic       receivable,
    input  logic       err_clear,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       tx_busy,
    output logic       Tx,
    input  logic       Rx
);
    localparam int DIV = CLOCKRATE / BAUDRATE;
    localparam int CW  = $clog2(2 * DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
    localparam logic [CW-1:0] MID      = CW'(DIV / 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == 2);
    localparam logic          HAS_PAR  = (PARITY != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // ---------------- transmitter ----------------
    state_t               tx_state, tx_state_d;
    logic [CW-1:0]        tx_cnt, tx_cnt_d;
    logic [BW-1:0]        tx_bit, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
    logic                 tx_par, tx_par_d;
    logic                 tx_line, tx_line_d;
    logic                 tx_pop, tx_load, tx_push;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_full, tx_empty;

    assign tx_push = send_flag && !tx_full;

    uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk(CLK), .rst_n(RST_N),
        .push(tx_push), .wdata(send_data[DATA_BITS-1:0]),
        .pop(tx_pop), .head(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + CW'(1);
        tx_bit_d   = tx_bit;
        tx_sh_d    = tx_sh;
        tx_par_d   = tx_par;
        tx_line_d  = tx_line;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        unique case (tx_state)
            IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                tx_load   = !tx_empty;
            end
            START: if (tx_cnt == BIT_END) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = DATA;
                tx_line_d  = tx_sh[0];
            end
            DATA: if (tx_cnt == BIT_END) begin
                tx_cnt_d = '0;
                tx_sh_d  = tx_sh >> 1;
                if (tx_bit == LAST_BIT) begin
                    tx_state_d = HAS_PAR ? PAR : STOP;
                    tx_line_d  = HAS_PAR ? tx_par : 1'b1;
                end else begin
                    tx_bit_d  = tx_bit + BW'(1);
                    tx_line_d = tx_sh_d[0];
                end
            end
            PAR: if (tx_cnt == BIT_END) begin
                tx_cnt_d   = '0;
                tx_state_d = STOP;
                tx_line_d  = 1'b1;
            end
            STOP: if (tx_cnt == STOP_END) begin
                tx_cnt_d   = '0;
                tx_state_d = IDLE;
                tx_line_d  = 1'b1;
                tx_load    = !tx_empty;
            end
            default: tx_state_d = IDLE;
        endcase
        // start bit goes out on the same edge the byte is popped
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_par_d   = (^tx_head) ^ ODD;
            tx_line_d  = 1'b0;
            tx_cnt_d   = '0;
            tx_state_d = START;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_sh    <= tx_sh_d;
            tx_par   <= tx_par_d;
            tx_line  <= tx_line_d;
        end
    end

    assign Tx       = tx_line;
    assign sendable = !tx_full;
    assign tx_busy  = (tx_state != IDLE) || !tx_empty;

    // ---------------- receiver ----------------
    logic [1:0]           sync;
    logic                 rxs;
    state_t               rx_state, rx_state_d;
    logic [CW-1:0]        rx_cnt, rx_cnt_d;
    logic [BW-1:0]        rx_bit, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
    logic                 bad_par, bad_par_d;
    logic                 rx_wr, set_par, set_frame, set_ovr;
    logic [DATA_BITS-1:0] rx_head;
    logic                 rx_full, rx_empty;

    assign rxs = sync[1];

    uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk(CLK), .rst_n(RST_N),
        .push(rx_wr), .wdata(rx_sh),
        .pop(recv_flag), .head(rx_head),
        .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + CW'(1);
        rx_bit_d   = rx_bit;
        rx_sh_d    = rx_sh;
        bad_par_d  = bad_par;
        rx_wr      = 1'b0;
        set_par    = 1'b0;
        set_frame  = 1'b0;
        set_ovr    = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_cnt_d = '0;
                if (!rxs) begin
                    rx_state_d = START;
                    bad_par_d  = 1'b0;
                end
            end
            START: begin
                if (rx_cnt == MID && rxs) begin
                    rx_state_d = IDLE;
                end else if (rx_cnt == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = DATA;
                end
            end
            DATA: begin
                if (rx_cnt == MID) rx_sh_d = {rxs, rx_sh[DATA_BITS-1:1]};
                if (rx_cnt == BIT_END) begin
                    rx_cnt_d = '0;
                    if (rx_bit == LAST_BIT) rx_state_d = HAS_PAR ? PAR : STOP;
                    else rx_bit_d = rx_bit + BW'(1);
                end
            end
            PAR: begin
                if (rx_cnt == MID && rxs != ((^rx_sh) ^ ODD)) bad_par_d = 1'b1;
                if (rx_cnt == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = STOP;
                end
            end
            STOP: if (rx_cnt == MID) begin
                // leave mid stop bit so the next start edge is never missed
                rx_state_d = IDLE;
                rx_cnt_d   = '0;
                if (!rxs) set_frame = 1'b1;
                else if (bad_par) set_par = 1'b1;
                else if (rx_full && !recv_flag) set_ovr = 1'b1;
                else rx_wr = 1'b1;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync       <= 2'b11;
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            bad_par    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync       <= {sync[0], Rx};
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_sh      <= rx_sh_d;
            bad_par    <= bad_par_d;
            parity_err <= set_par   | (parity_err & ~err_clear);
            frame_err  <= set_frame | (frame_err  & ~err_clear);
            overrun    <= set_ovr   | (overrun    & ~err_clear);
        end
    end

    assign receivable = !rx_empty;
    assign recv_data  = rx_empty ? 8'h00 : 8'(rx_head);
endmodule
